// File: rtl/uart_rx_ctrl_if.sv
// Serial receive bundle: line input, byte handshake to the host and status.
// master drives the line and rx_ready; slave is the receiver.
interface uart_rx_ctrl_if;
  logic       din;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun_err;
  logic       busy;

  modport master (
    output din, rx_ready,
    input  rx_data, rx_valid, frame_err, overrun_err, busy
  );

  modport slave (
    input  din, rx_ready,
    output rx_data, rx_valid, frame_err, overrun_err, busy
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receiver: oversample tick, start detect, mid-bit sampling,
// stop check and a small byte FIFO with valid/ready output.
module uart_rx_ctrl #(
  parameter int CLK_PER_TICK = 10,
  parameter int SAMPLE_RATIO = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input logic         clk,
  input logic         rst,
  uart_rx_ctrl_if.slave rx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0] HALF_M1 = 4'(SAMPLE_RATIO / 2 - 1);
  localparam logic [3:0] FULL_M1 = 4'(SAMPLE_RATIO - 1);
  localparam logic [15:0] TICK_M1 = 16'(CLK_PER_TICK - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync2_q;
  logic [15:0] tcnt_q;
  logic [3:0]  pcnt_q, pcnt_d;
  logic [3:0]  bidx_q, bidx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        fe_q, fe_d;
  logic        ov_q, ov_d;
  logic        push;
  logic        pop;
  logic        full;
  logic        tick;
  logic        din_s;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;

  assign din_s = sync2_q;
  assign tick  = (tcnt_q == TICK_M1);
  assign full  = (cnt_q == CW'(FIFO_DEPTH));
  assign pop   = rx.rx_valid & rx.rx_ready;

  assign rx.rx_valid    = (cnt_q != '0);
  assign rx.rx_data     = mem_q[rd_ptr_q];
  assign rx.busy        = (state_q != IDLE);
  assign rx.frame_err   = fe_q;
  assign rx.overrun_err = ov_q;

  // Line idles high, so the synchronizer resets to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx.din;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tcnt_q <= '0;
    else if (tick) tcnt_q <= '0;
    else tcnt_q <= tcnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      bidx_q  <= '0;
      shreg_q <= '0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      bidx_q  <= bidx_d;
      shreg_q <= shreg_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    bidx_d  = bidx_q;
    shreg_d = shreg_q;
    fe_d    = 1'b0;
    ov_d    = 1'b0;
    push    = 1'b0;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (!din_s) begin
            state_d = START;
            pcnt_d  = '0;
          end
        end
        START: begin
          if (pcnt_q == HALF_M1) begin
            pcnt_d = '0;
            bidx_d = '0;
            state_d = din_s ? IDLE : DATA;
          end else begin
            pcnt_d = pcnt_q + 4'd1;
          end
        end
        DATA: begin
          if (pcnt_q == FULL_M1) begin
            shreg_d = {din_s, shreg_q[7:1]};
            pcnt_d  = '0;
            bidx_d  = bidx_q + 4'd1;
            if (bidx_q == 4'd7) state_d = STOP;
          end else begin
            pcnt_d = pcnt_q + 4'd1;
          end
        end
        STOP: begin
          if (pcnt_q == FULL_M1) begin
            state_d = IDLE;
            pcnt_d  = '0;
            // A pop in the same clk frees the slot a full FIFO needs.
            if (!din_s) fe_d = 1'b1;
            else if (!full || pop) push = 1'b1;
            else ov_d = 1'b1;
          end else begin
            pcnt_d = pcnt_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= shreg_q;
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end
endmodule
